// File: rtl/imem_req.sv
// -----------------------------------------------------------------------------
// imem_req : instruction-memory request unit between the fetch register and
//            the decode register. It issues one bus request at a time and
//            delivers the returned word, or a fault, to the fetch stage.
//
// Parameters
//   NOP_INSTR        word presented on raw_instr after reset and on a fault
//
// Ports
//   clk              sole clock, rising edge
//   resetn           asynchronous active-low reset
//   pc, pc_valid     fetch address and its valid flag from the fetch register
//   is_usermode      current privilege is user
//   flush            redirect: abandon the current fetch
//   stall_down       decode register not accepting this cycle
//   ireq_valid/addr  bus address request (held until ireq_ready)
//   ireq_ready       bus accepted the address this cycle
//   iresp_valid/data bus response
//   raw_instr        instruction word to the fetch stage
//   instr_valid      raw_instr / exception_instr valid
//   exception_instr  fetch address fault
//   stall_fetch      fetch register must hold pc
//
// Build option
//   IMEM_USER_ADDR_CHECK_EN  when defined, a user-mode fetch from an address
//                            with pc[31] set faults without a bus request.
// -----------------------------------------------------------------------------
module imem_req #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pc,
   input  logic        pc_valid,
   input  logic        is_usermode,
   input  logic        flush,
   input  logic        stall_down,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   output logic [31:0] raw_instr,
   output logic        instr_valid,
   output logic        exception_instr,
   output logic        stall_fetch
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DISCARD,
      S_HOLD
   } state_t;

   state_t      r_state;
   logic        r_flush_pend;
   logic        r_ireq_valid;
   logic [31:0] r_ireq_addr;
   logic [31:0] r_raw_instr;
   logic        r_instr_valid;
   logic        r_exception;
   logic        w_bad_pc;

`ifdef IMEM_USER_ADDR_CHECK_EN
   assign w_bad_pc = (|pc[1:0]) | (is_usermode & pc[31]);
`else
   // Without the user check the privilege level has no effect on fetch.
   logic w_unused_usermode;
   assign w_unused_usermode = is_usermode;
   assign w_bad_pc = |pc[1:0];
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_flush_pend  <= 1'b0;
         r_ireq_valid  <= 1'b0;
         r_ireq_addr   <= '0;
         r_raw_instr   <= NOP_INSTR;
         r_instr_valid <= 1'b0;
         r_exception   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_flush_pend <= 1'b0;
               if (pc_valid && !flush) begin
                  if (w_bad_pc) begin
                     r_raw_instr   <= NOP_INSTR;
                     r_exception   <= 1'b1;
                     r_instr_valid <= 1'b1;
                     r_state       <= S_HOLD;
                  end else begin
                     r_ireq_addr  <= pc;
                     r_ireq_valid <= 1'b1;
                     r_state      <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               // The address phase must complete even after a flush; the
               // flush is remembered so the response gets discarded.
               r_flush_pend <= r_flush_pend | flush;
               if (ireq_ready) begin
                  r_ireq_valid <= 1'b0;
                  r_state      <= (flush || r_flush_pend) ? S_DISCARD : S_WAIT;
               end
            end
            S_WAIT: begin
               if (iresp_valid) begin
                  if (flush || r_flush_pend) begin
                     r_flush_pend <= 1'b0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_raw_instr   <= iresp_data;
                     r_exception   <= 1'b0;
                     r_instr_valid <= 1'b1;
                     r_state       <= S_HOLD;
                  end
               end else if (flush) begin
                  r_state <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (iresp_valid) begin
                  r_flush_pend <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (flush || !stall_down) begin
                  r_instr_valid <= 1'b0;
                  r_flush_pend  <= 1'b0;
                  r_state       <= S_IDLE;
               end
            end
            default: begin
               r_flush_pend <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign ireq_valid      = r_ireq_valid;
   assign ireq_addr       = r_ireq_addr;
   assign raw_instr       = r_raw_instr;
   assign instr_valid     = r_instr_valid;
   assign exception_instr = r_exception;
   assign stall_fetch     = pc_valid & ((r_state != S_HOLD) | stall_down);

endmodule

// File: doc/imem_req.md
IMEM_REQ -- requirements
Module: imem_req

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, instruction word delivered on exception or reset; SHALL be honoured.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 pc  input  32  fetch address from fetch register.
REQ-005 pc_valid  input  1  pc holds an instruction to fetch.
REQ-006 is_usermode  input  1  current privilege is user.
REQ-007 flush  input  1  redirect; current fetch SHALL be abandoned.
REQ-008 stall_down  input  1  decode register not accepting this cycle.
REQ-009 ireq_valid  output  1  instruction bus address request.
REQ-010 ireq_addr  output  32  request address.
REQ-011 ireq_ready  input  1  bus accepted address this cycle.
REQ-012 iresp_valid  input  1  response data valid.
REQ-013 iresp_data  input  32  response instruction word.
REQ-014 raw_instr  output  32  instruction to fetch stage.
REQ-015 instr_valid  output  1  raw_instr/exception_instr valid.
REQ-016 exception_instr  output  1  fetch address fault.
REQ-017 stall_fetch  output  1  fetch register SHALL hold pc.

Function
REQ-018 States IDLE, REQ, WAIT, DISCARD, HOLD; at most one outstanding bus request.
REQ-019 bad_pc = |pc[1:0] (plus user check per REQ-033); evaluated in IDLE only.
REQ-020 IDLE, pc_valid & !flush & !bad_pc: latch pc into ireq_addr, -> REQ.
REQ-021 IDLE, pc_valid & !flush & bad_pc: no request; raw_instr<=NOP_INSTR, exception_instr<=1, -> HOLD.
REQ-022 REQ: ireq_valid=1, ireq_addr stable until ireq_ready; ireq_valid SHALL NOT drop before ireq_ready, even on flush.
REQ-023 REQ & ireq_ready: -> WAIT, or -> DISCARD if flush seen this cycle or since entering REQ (sticky flush_pend).
REQ-024 WAIT & iresp_valid & !(flush|flush_pend): raw_instr<=iresp_data, exception_instr<=0, -> HOLD.
REQ-025 WAIT & iresp_valid & (flush|flush_pend): data dropped, -> IDLE.
REQ-026 WAIT & flush & !iresp_valid: -> DISCARD.
REQ-027 DISCARD: iresp_valid -> IDLE, data never delivered.
REQ-028 HOLD: instr_valid=1; flush -> IDLE (instr_valid 0 next cycle); !stall_down -> IDLE; else hold outputs unchanged.
REQ-029 stall_fetch = pc_valid & (state != HOLD | stall_down).
REQ-030 Minimum latency: pc_valid cycle 0, ireq_valid cycle 1, ireq_ready cycle 1, iresp_valid cycle 2, instr_valid cycle 3.
REQ-031 flush_pend cleared on entering IDLE; pc changes outside IDLE SHALL be ignored.

Reset
REQ-032 resetn low: state IDLE, ireq_valid 0, ireq_addr 0, raw_instr NOP_INSTR, instr_valid 0, exception_instr 0, flush_pend 0, immediately and regardless of in-flight request; a response arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-033 Macro IMEM_USER_ADDR_CHECK_EN defined: bad_pc additionally includes is_usermode & pc[31] (no bus request issued); undefined: only misalignment faults, kseg addresses fetched in user mode.

Verification
REQ-034 pc=0xBFC0_0000, pc_valid=1, ireq_ready same cycle, iresp_valid next cycle with 0x2408_0001 -> instr_valid cycle 3, raw_instr 0x2408_0001, exception_instr 0.
REQ-035 pc=0xBFC0_0002 -> no ireq_valid; cycle 1 instr_valid=1, exception_instr=1, raw_instr=NOP_INSTR.
REQ-036 ireq_ready held low 3 cycles with flush in cycle 2 -> ireq_valid stays high until accepted, state DISCARD, response 0xDEAD_BEEF never appears on raw_instr.
REQ-037 Response captured, stall_down=1 for 4 cycles -> instr_valid and raw_instr stable 4 cycles, stall_fetch=1; new request only after stall_down drops.
REQ-038 Macro defined, is_usermode=1, pc=0x8000_0000 -> no request, exception_instr=1; macro undefined -> request issued to 0x8000_0000.
REQ-039 resetn asserted in WAIT -> all outputs reset values that cycle; late iresp_valid ignored, instr_valid stays 0.
